// File: rtl/keypad_synth.sv
// rtl/keypad_synth.sv - keypad-to-tone synthesiser with octave shift, mute and attack/release envelope
// Drives the PWM amplifier pins; one note sounds at a time, chosen by key priority.
module keypad_synth #(
    parameter int NUM_KEYS        = 16,
    parameter int DIV_W           = 18,
    parameter int VOL_W           = 8,
    parameter logic [NUM_KEYS*DIV_W-1:0] NOTE_TABLE = {
        18'd80354,  18'd85131,  18'd90193,  18'd95557,
        18'd101239, 18'd107259, 18'd113636, 18'd120395,
        18'd127551, 18'd135139, 18'd143172, 18'd151685,
        18'd160705, 18'd170265, 18'd180388, 18'd191110
    },
    parameter int OCT_MAX         = 2,
    parameter int ENV_STEP_CYCLES = 1000,
    parameter int PRIORITY        = 0,
    localparam int KEY_W  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
    localparam int OCT_W  = (OCT_MAX > 0) ? $clog2(OCT_MAX + 1) : 1
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic [NUM_KEYS-1:0] keys,
    input  logic                mute_tgl,
    input  logic                oct_up,
    input  logic                oct_dn,
    input  logic [VOL_W-1:0]    volume,
    output logic                ain,
    output logic                gain,
    output logic                shutdown_l,
    output logic                note_on,
    output logic [KEY_W-1:0]    active_key,
    output logic [OCT_W-1:0]    octave,
    output logic                muted
);

    localparam int TICK_W = (ENV_STEP_CYCLES > 1) ? $clog2(ENV_STEP_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [VOL_W-1:0]    env_q, env_d;
    logic [VOL_W-1:0]    pc_q, pc_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d;
    logic                sq_q, sq_d;
    logic                ain_q, ain_d;
    logic                shutdown_l_q, shutdown_l_d;
    logic                note_on_q, note_on_d;
    logic [KEY_W-1:0]    active_key_q, active_key_d;
    logic [OCT_W-1:0]    octave_q, octave_d;
    logic                muted_q, muted_d;

    logic [KEY_W-1:0]    key_sel;
    logic [DIV_W-1:0]    half;
    logic                tick;
    logic                retune;

    always_comb begin
        key_sel = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (PRIORITY == 0) begin
                if (keys[NUM_KEYS-1-k]) key_sel = KEY_W'(NUM_KEYS - 1 - k);
            end else begin
                if (keys[k]) key_sel = KEY_W'(k);
            end
        end
    end

    // Pitch follows the registered key/octave so the last note keeps playing through release.
    assign half = NOTE_TABLE[int'(active_key_q) * DIV_W +: DIV_W] >> octave_q;
    assign tick = (tick_q == TICK_W'(ENV_STEP_CYCLES - 1));

    always_comb begin
        muted_d      = muted_q ^ mute_tgl;
        note_on_d    = (keys != '0) & ~muted_d;
        active_key_d = note_on_d ? key_sel : active_key_q;

        octave_d = octave_q;
        if (oct_up && !oct_dn && octave_q != OCT_W'(OCT_MAX)) octave_d = octave_q + OCT_W'(1);
        if (oct_dn && !oct_up && octave_q != '0)              octave_d = octave_q - OCT_W'(1);

        retune = (active_key_d != active_key_q) | (octave_d != octave_q);

        cnt_d = cnt_q + DIV_W'(1);
        sq_d  = sq_q;
        if (retune || half == '0) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (cnt_q >= half - DIV_W'(1)) begin
            cnt_d = '0;
            sq_d  = ~sq_q;
        end

        tick_d = tick ? '0 : tick_q + TICK_W'(1);
        pc_d   = pc_q + VOL_W'(1);
        ain_d  = sq_q & (pc_q < env_q);
    end

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        case (state_q)
            IDLE: begin
                env_d = '0;
                if (note_on_q) state_d = ATTACK;
            end
            ATTACK: begin
                if (!note_on_q)          state_d = RELEASE;
                else if (env_q >= volume) state_d = SUSTAIN;
                else if (tick && env_q != {VOL_W{1'b1}}) env_d = env_q + VOL_W'(1);
            end
            SUSTAIN: begin
                if (!note_on_q) state_d = RELEASE;
                else if (tick) begin
                    if (env_q < volume)      env_d = env_q + VOL_W'(1);
                    else if (env_q > volume) env_d = env_q - VOL_W'(1);
                end
            end
            RELEASE: begin
                if (note_on_q)        state_d = ATTACK;
                else if (env_q == '0) state_d = IDLE;
                else if (tick) begin
                    env_d = env_q - VOL_W'(1);
                    // Land in IDLE on the same edge env hits zero so shutdown tracks it exactly.
                    if (env_q == VOL_W'(1)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        shutdown_l_d = ~(muted_d & (state_d == IDLE));
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q      <= IDLE;
            env_q        <= '0;
            pc_q         <= '0;
            tick_q       <= '0;
            cnt_q        <= '0;
            sq_q         <= 1'b0;
            ain_q        <= 1'b0;
            shutdown_l_q <= 1'b1;
            note_on_q    <= 1'b0;
            active_key_q <= '0;
            octave_q     <= '0;
            muted_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            env_q        <= env_d;
            pc_q         <= pc_d;
            tick_q       <= tick_d;
            cnt_q        <= cnt_d;
            sq_q         <= sq_d;
            ain_q        <= ain_d;
            shutdown_l_q <= shutdown_l_d;
            note_on_q    <= note_on_d;
            active_key_q <= active_key_d;
            octave_q     <= octave_d;
            muted_q      <= muted_d;
        end
    end

    assign ain        = ain_q;
    assign gain       = 1'b1;
    assign shutdown_l = shutdown_l_q;
    assign note_on    = note_on_q;
    assign active_key = active_key_q;
    assign octave     = octave_q;
    assign muted      = muted_q;

endmodule

// File: tb/tb_keypad_synth.sv
// tb/tb_keypad_synth.sv - directed self-checking bench for keypad_synth
module tb_keypad_synth;

    localparam logic [16*18-1:0] TB_TABLE = {{12{18'd20}}, 18'd10, {3{18'd20}}};

    logic        clk = 1'b0;
    logic        rst_l;
    logic [15:0] keys;
    logic        mute_tgl, oct_up, oct_dn;
    logic [7:0]  volume;

    logic       ain, gain, shutdown_l, note_on, muted;
    logic [3:0] active_key;
    logic [1:0] octave;
    logic       ain_h, gain_h, shutdown_l_h, note_on_h, muted_h;
    logic [3:0] active_key_h;
    logic [1:0] octave_h;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    keypad_synth #(
        .NOTE_TABLE(TB_TABLE), .ENV_STEP_CYCLES(1), .PRIORITY(0)
    ) dut (
        .clk(clk), .rst_l(rst_l), .keys(keys), .mute_tgl(mute_tgl),
        .oct_up(oct_up), .oct_dn(oct_dn), .volume(volume),
        .ain(ain), .gain(gain), .shutdown_l(shutdown_l), .note_on(note_on),
        .active_key(active_key), .octave(octave), .muted(muted)
    );

    keypad_synth #(
        .NOTE_TABLE(TB_TABLE), .ENV_STEP_CYCLES(1), .PRIORITY(1)
    ) dut_hi (
        .clk(clk), .rst_l(rst_l), .keys(keys), .mute_tgl(mute_tgl),
        .oct_up(oct_up), .oct_dn(oct_dn), .volume(volume),
        .ain(ain_h), .gain(gain_h), .shutdown_l(shutdown_l_h), .note_on(note_on_h),
        .active_key(active_key_h), .octave(octave_h), .muted(muted_h)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input string tag);
        int n;
        n = 0;
        while (dut.state_q != s && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(dut.state_q), 32'(s));
    endtask

    task automatic measure_half(output int n);
        logic s;
        int   g;
        s = dut.sq_q;
        g = 0;
        do begin @(negedge clk); g++; end while (dut.sq_q == s && g < 200);
        s = dut.sq_q;
        n = 0;
        do begin @(negedge clk); n++; end while (dut.sq_q == s && n < 200);
    endtask

    task automatic pulse_oct(input logic up, input logic dn);
        oct_up = up;
        oct_dn = dn;
        @(negedge clk);
        oct_up = 1'b0;
        oct_dn = 1'b0;
    endtask

    initial begin
        int h, hi_cnt;
        rst_l = 1'b0; keys = '0; mute_tgl = 1'b0; oct_up = 1'b0; oct_dn = 1'b0; volume = '0;
        repeat (2) @(negedge clk);
        check("rst_ain", ain, 0);
        check("rst_gain", gain, 1);
        check("rst_shutdown", shutdown_l, 1);
        check("rst_note_on", note_on, 0);
        check("rst_octave", octave, 0);
        check("rst_muted", muted, 0);
        rst_l = 1'b1;
        @(negedge clk);

        // Tone on key 3 (half period 10) at full volume
        volume = 8'd255;
        keys   = 16'h0008;
        repeat (300) @(negedge clk);
        check("tone_key", active_key, 3);
        check("tone_note_on", note_on, 1);
        check("tone_state", 32'(dut.state_q), 2);
        check("tone_env", dut.env_q, 255);
        measure_half(h); check("tone_half_a", h, 10);
        measure_half(h); check("tone_half_b", h, 10);
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ain) hi_cnt++;
        end
        check("tone_ain_duty", (hi_cnt >= 9 && hi_cnt <= 10), 1);

        // Asynchronous reset in the middle of the tone
        rst_l = 1'b0;
        #1;
        check("midrst_ain", ain, 0);
        check("midrst_shutdown", shutdown_l, 1);
        check("midrst_gain", gain, 1);
        check("midrst_env", dut.env_q, 0);
        check("midrst_state", 32'(dut.state_q), 0);
        check("midrst_key", active_key, 0);
        keys = '0;
        @(negedge clk);
        rst_l = 1'b1;
        @(negedge clk);

        keys = 16'h0014;
        @(negedge clk);
        check("prio_low", active_key, 2);
        check("prio_high", active_key_h, 4);

        keys = 16'h0008;
        @(negedge clk);
        repeat (3) pulse_oct(1'b1, 1'b0);
        check("oct_sat", octave, 2);
        measure_half(h); check("oct2_half", h, 2);
        pulse_oct(1'b1, 1'b1);
        check("oct_both", octave, 2);
        pulse_oct(1'b0, 1'b1);
        check("oct_dn", octave, 1);
        measure_half(h); check("oct1_half", h, 5);

        // Envelope ramp to volume 4 and release
        keys   = '0;
        volume = 8'd4;
        wait_state(2'd0, "env_idle_wait");
        keys = 16'h0001;
        wait_state(2'd1, "env_attack_wait");
        check("env_att0", dut.env_q, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("env_att", dut.env_q, i);
        end
        @(negedge clk);
        check("env_sustain", 32'(dut.state_q), 2);
        check("env_sus_lvl", dut.env_q, 4);
        keys = '0;
        wait_state(2'd3, "env_release_wait");
        check("env_rel4", dut.env_q, 4);
        for (int i = 3; i >= 1; i--) begin
            @(negedge clk);
            check("env_rel", dut.env_q, i);
        end
        @(negedge clk);
        check("env_rel0", dut.env_q, 0);
        check("env_rel_idle", 32'(dut.state_q), 0);

        // Mute while sustaining; shutdown only once the release ends
        keys = 16'h0001;
        wait_state(2'd2, "mute_sus_wait");
        repeat (2) @(negedge clk);
        check("mute_env4", dut.env_q, 4);
        mute_tgl = 1'b1;
        @(negedge clk);
        mute_tgl = 1'b0;
        check("mute_note_off", note_on, 0);
        check("mute_flag", muted, 1);
        check("mute_sd_hold", shutdown_l, 1);
        for (int i = 4; i >= 1; i--) begin
            @(negedge clk);
            check("mute_rel_env", dut.env_q, i);
            check("mute_rel_sd", shutdown_l, 1);
        end
        @(negedge clk);
        check("mute_env0", dut.env_q, 0);
        check("mute_sd_off", shutdown_l, 0);
        keys = '0;
        mute_tgl = 1'b1;
        @(negedge clk);
        mute_tgl = 1'b0;
        check("unmute_flag", muted, 0);
        check("unmute_sd_on", shutdown_l, 1);

        // Zero volume: attack ends at once, output stays silent
        volume = '0;
        keys   = 16'h0002;
        wait_state(2'd1, "vol0_attack_wait");
        @(negedge clk);
        check("vol0_sustain", 32'(dut.state_q), 2);
        check("vol0_env", dut.env_q, 0);
        hi_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ain) hi_cnt++;
        end
        check("vol0_silent", hi_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
